dma_timing_control: RTL and testbench
=====================================

Name: dma_timing_control

Overview:
- Transfer sequencer for the 4-channel DMA controller, upstream of the priority/DACK stage.
- Requests the bus (HRQ/HLDA) and raises assertDACK so the priority stage can grant one channel.
- Latches the granted DACK, runs one single-mode transfer cycle (S0..S4 with wait states), and drives the bus strobes.
- Keeps per-channel current word counts and signals terminal count (TC) and EOP.

Parameters:
- NUM_CH, 4, number of DMA channels; DREQ/DACK/TC vectors are NUM_CH wide.
- CNT_W, 16, word-count register width.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- DREQ  in  NUM_CH  masked channel requests, already synchronous to CLK.
- DACK  in  NUM_CH  one-hot grant from the priority stage; valid while assertDACK=1.
- HLDA  in  1  hold acknowledge from the CPU.
- READY  in  1  0 inserts wait states.
- EOP_n_in  in  1  external end-of-process, active low.
- xferType  in  NUM_CH*2  per channel: 00 verify, 01 write (IOR+MEMW), 10 read (MEMR+IOW), 11 treated as verify.
- autoInit  in  NUM_CH  per-channel auto-initialise enable.
- cntLoad  in  1  one-cycle load strobe from the register file.
- cntLoadCh  in  2  channel being loaded.
- cntLoadVal  in  CNT_W  base and current count value.
- HRQ  out  1  hold request.
- AEN  out  1  address enable.
- ADSTB  out  1  address strobe.
- assertDACK  out  1  enables DACK generation in the priority stage.
- MEMR_n, MEMW_n, IOR_n, IOW_n  out  1 each  bus strobes, active low.
- EOP_n_out  out  1  internal TC pulse, active low.
- tcStatus  out  NUM_CH  sticky TC flags.
- activeCh  out  2  index of the latched channel.
- decCount  out  1  one-cycle pulse; tells the address stage to step the address of activeCh.

Behaviour:
- Reset values:
  - state=SI.
  - HRQ=0, AEN=0, ADSTB=0, assertDACK=0.
  - All strobes=1, EOP_n_out=1.
  - tcStatus=0, activeCh=0, decCount=0.
  - All current and base counts=0.
- RESET asserted mid-transfer returns every output to these values immediately (asynchronous).
- SI: if |DREQ, then HRQ<=1 and go to S0.
- S0: hold HRQ=1.
  - If HLDA=1, go to S1.
  - If DREQ drops to 0 while in S0, clear HRQ and return to SI.
- S1:
  - assertDACK=1, AEN=1, ADSTB=1.
  - If DACK==0, return to SI and drop HRQ.
  - Otherwise latch activeCh=encode(DACK) and latch the channel's xferType; go to S2.
  - assertDACK stays 1 from S1 through S4.
- S2: ADSTB=0, AEN=1.
  - Read type: MEMR_n=0.
  - Write type: IOR_n=0.
  - Go to S3.
- S3: the S2 strobe stays low and the second strobe goes low (read type: IOW_n; write type: MEMW_n).
  - If READY=0, go to SW; else go to S4.
- SW: strobes held; stay while READY=0; go to S4 when READY=1.
- S4:
  - All strobes=1, decCount=1 for one cycle.
  - Current count of activeCh decrements by 1, wrapping 0 -> all-ones.
  - TC occurs when the count was 0 before the decrement, so N loaded gives N+1 transfers.
  - Next state is SI with HRQ<=0 and AEN<=0 (single mode: one transfer per grant).
- Verify type: no strobes asserted; timing and counting are identical to the other types.
- TC, or EOP_n_in=0 sampled in any of S1..S4:
  - EOP_n_out=0 for the S4 cycle only.
  - tcStatus[activeCh]<=1.
  - If autoInit[activeCh]=1, current count reloads from base in S4; otherwise it holds the wrapped value.
- An external EOP sampled in SI or S0 is ignored.
- cntLoad: base[cntLoadCh] and current[cntLoadCh] <= cntLoadVal, and tcStatus[cntLoadCh] clears.
  - If cntLoad coincides with an S4 decrement of the same channel, the load wins.
- HLDA falling during S1..S4 does not abort; the cycle completes and the next request restarts at S0.
- No combinational path from DREQ to HRQ; all control outputs are registered.

Decomposition:
- Shared package dma_pkg:
  - state enum {SI,S0,S1,S2,S3,SW,S4}.
  - xferType constants XFER_VERIFY, XFER_WRITE, XFER_READ.
  - NUM_CH and CNT_W defaults.
- One sub-module, dma_word_counter, is natural: per-channel base/current count bank with load, decrement, wrap, TC detect and autoinit reload.

Test Plan:
- Write transfer, no waits: ch2 count=0x0001, xferType=01, DREQ=4'b0100, HLDA one cycle after HRQ.
  - Expected: IOR_n low in S2-S3, MEMW_n low in S3, HRQ low after S4.
  - Count goes to 0; no TC.
- Terminal count: repeat the same request.
  - Expected: count 0 -> 0xFFFF, EOP_n_out low one cycle in S4, tcStatus=4'b0100.
- Wait states: read transfer with READY=0 for 3 cycles from S3.
  - Expected: MEMR_n and IOW_n held low for exactly 3 extra cycles; decCount pulses once.
- Autoinit: ch0 loaded with 0x0000, autoInit=1.
  - Expected: TC fires and current count returns to 0x0000 rather than 0xFFFF.
- Abort and reset:
  - DREQ withdrawn in S0: HRQ=0 and state SI with no strobes.
  - RESET mid-S3: all strobes=1 and HRQ=0 in the same cycle.
- Load/decrement collision: cntLoad of ch1 with 0x0010 in the S4 cycle of ch1.
  - Expected: current count is 0x0010, tcStatus[1]=0.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module : dma_pkg
// Brief  : Shared types and constants for the DMA transfer sequencer.
// Rev    : 1.0
// ============================================================================
package dma_pkg;

    localparam int DMA_NUM_CH = 4;
    localparam int DMA_CNT_W  = 16;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6
    } dmaState_t;

    localparam logic [1:0] XFER_VERIFY = 2'b00;
    localparam logic [1:0] XFER_WRITE  = 2'b01;
    localparam logic [1:0] XFER_READ   = 2'b10;

    // The reserved encoding 11 behaves exactly like a verify cycle.
    function automatic logic [1:0] decodeXfer(input logic [1:0] raw);
        return (raw == 2'b11) ? XFER_VERIFY : raw;
    endfunction

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_word_counter.sv
`default_nettype none
// ============================================================================
// Module : dma_word_counter
// Brief  : Per-channel base/current word counts with load, decrement, wrap,
//          terminal-count detect, auto-initialise reload and sticky TC flags.
// Rev    : 1.0
// ============================================================================
module dma_word_counter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load,
    input  logic [CH_W-1:0]   loadCh,
    input  logic [CNT_W-1:0]  loadVal,
    input  logic              dec,
    input  logic [CH_W-1:0]   ch,
    input  logic              termHit,
    input  logic [NUM_CH-1:0] autoInit,
    output logic              countZero,
    output logic [NUM_CH-1:0] tcStatus
);

    logic [CNT_W-1:0]  r_base    [NUM_CH];
    logic [CNT_W-1:0]  r_current [NUM_CH];
    logic [NUM_CH-1:0] r_tcStatus;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_base[i]    <= '0;
                r_current[i] <= '0;
            end
            r_tcStatus <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A register-file load takes precedence over a same-cycle decrement.
                if (load && (loadCh == CH_W'(i))) begin
                    r_base[i]     <= loadVal;
                    r_current[i]  <= loadVal;
                    r_tcStatus[i] <= 1'b0;
                end else if (dec && (ch == CH_W'(i))) begin
                    if (termHit) begin
                        r_tcStatus[i] <= 1'b1;
                        r_current[i]  <= autoInit[i] ? r_base[i] : (r_current[i] - 1'b1);
                    end else begin
                        r_current[i]  <= r_current[i] - 1'b1;
                    end
                end
            end
        end
    end

    assign countZero = (r_current[ch] == '0);
    assign tcStatus  = r_tcStatus;

endmodule : dma_word_counter
`default_nettype wire

// File: rtl/dma_timing_control.sv
`default_nettype none
// ============================================================================
// Module : dma_timing_control
// Brief  : Single-mode DMA transfer sequencer: bus request, DACK latch,
//          S0..S4 strobe timing with wait states, TC/EOP handling.
// Rev    : 1.0
// ============================================================================
module dma_timing_control
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CNT_W  = DMA_CNT_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NUM_CH-1:0]   DREQ,
    input  logic [NUM_CH-1:0]   DACK,
    input  logic                HLDA,
    input  logic                READY,
    input  logic                EOP_n_in,
    input  logic [NUM_CH*2-1:0] xferType,
    input  logic [NUM_CH-1:0]   autoInit,
    input  logic                cntLoad,
    input  logic [1:0]          cntLoadCh,
    input  logic [CNT_W-1:0]    cntLoadVal,
    output logic                HRQ,
    output logic                AEN,
    output logic                ADSTB,
    output logic                assertDACK,
    output logic                MEMR_n,
    output logic                MEMW_n,
    output logic                IOR_n,
    output logic                IOW_n,
    output logic                EOP_n_out,
    output logic [NUM_CH-1:0]   tcStatus,
    output logic [1:0]          activeCh,
    output logic                decCount
);

    localparam int CH_W = 2;

    dmaState_t   r_state;
    logic        r_hrq, r_aen, r_adstb, r_assertDack;
    logic        r_memrN, r_memwN, r_iorN, r_iowN;
    logic        r_eopOutN, r_decCount, r_eopSeen;
    logic [1:0]  r_xfer;
    logic [CH_W-1:0] r_activeCh;

    logic [CH_W-1:0] w_dackIdx;
    logic [1:0]      w_selType;
    logic            w_countZero;
    logic            w_term;

    // Lowest set DACK bit wins; the priority stage guarantees one-hot anyway.
    always_comb begin
        w_dackIdx = '0;
        w_selType = XFER_VERIFY;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (DACK[i]) begin
                w_dackIdx = CH_W'(i);
                w_selType = decodeXfer(xferType[2*i +: 2]);
            end
        end
    end

    assign w_term = w_countZero | r_eopSeen | ~EOP_n_in;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= SI;
            r_hrq        <= 1'b0;
            r_aen        <= 1'b0;
            r_adstb      <= 1'b0;
            r_assertDack <= 1'b0;
            r_memrN      <= 1'b1;
            r_memwN      <= 1'b1;
            r_iorN       <= 1'b1;
            r_iowN       <= 1'b1;
            r_eopOutN    <= 1'b1;
            r_decCount   <= 1'b0;
            r_eopSeen    <= 1'b0;
            r_xfer       <= XFER_VERIFY;
            r_activeCh   <= '0;
        end else begin
            r_decCount <= 1'b0;
            r_eopOutN  <= 1'b1;
            if ((r_state inside {S1, S2, S3, SW}) && !EOP_n_in)
                r_eopSeen <= 1'b1;

            case (r_state)
                SI: begin
                    r_eopSeen <= 1'b0;
                    if (|DREQ) begin
                        r_hrq   <= 1'b1;
                        r_state <= S0;
                    end
                end
                S0: begin
                    if (!(|DREQ)) begin
                        r_hrq   <= 1'b0;
                        r_state <= SI;
                    end else if (HLDA) begin
                        r_assertDack <= 1'b1;
                        r_aen        <= 1'b1;
                        r_adstb      <= 1'b1;
                        r_state      <= S1;
                    end
                end
                S1: begin
                    if (DACK == '0) begin
                        r_hrq        <= 1'b0;
                        r_assertDack <= 1'b0;
                        r_aen        <= 1'b0;
                        r_adstb      <= 1'b0;
                        r_state      <= SI;
                    end else begin
                        r_activeCh <= w_dackIdx;
                        r_xfer     <= w_selType;
                        r_adstb    <= 1'b0;
                        if (w_selType == XFER_READ)  r_memrN <= 1'b0;
                        if (w_selType == XFER_WRITE) r_iorN  <= 1'b0;
                        r_state    <= S2;
                    end
                end
                S2: begin
                    if (r_xfer == XFER_READ)  r_iowN  <= 1'b0;
                    if (r_xfer == XFER_WRITE) r_memwN <= 1'b0;
                    r_state <= S3;
                end
                S3, SW: begin
                    if (READY) begin
                        r_memrN    <= 1'b1;
                        r_memwN    <= 1'b1;
                        r_iorN     <= 1'b1;
                        r_iowN     <= 1'b1;
                        r_decCount <= 1'b1;
                        r_eopOutN  <= ~w_term;
                        r_state    <= S4;
                    end else begin
                        r_state <= SW;
                    end
                end
                S4: begin
                    r_hrq        <= 1'b0;
                    r_aen        <= 1'b0;
                    r_assertDack <= 1'b0;
                    r_eopSeen    <= 1'b0;
                    r_state      <= SI;
                end
                default: r_state <= SI;
            endcase
        end
    end

    dma_word_counter #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) u_wordCounter (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (cntLoad),
        .loadCh    (cntLoadCh),
        .loadVal   (cntLoadVal),
        .dec       (r_decCount),
        .ch        (r_activeCh),
        .termHit   (~r_eopOutN),
        .autoInit  (autoInit),
        .countZero (w_countZero),
        .tcStatus  (tcStatus)
    );

    assign HRQ        = r_hrq;
    assign AEN        = r_aen;
    assign ADSTB      = r_adstb;
    assign assertDACK = r_assertDack;
    assign MEMR_n     = r_memrN;
    assign MEMW_n     = r_memwN;
    assign IOR_n      = r_iorN;
    assign IOW_n      = r_iowN;
    assign EOP_n_out  = r_eopOutN;
    assign activeCh   = r_activeCh;
    assign decCount   = r_decCount;

endmodule : dma_timing_control
`default_nettype wire

// File: tb/tb_dma_timing_control.sv
`default_nettype none
// ============================================================================
// Module : tb_dma_timing_control
// Brief  : Directed self-checking bench for the DMA transfer sequencer.
// Rev    : 1.0
// ============================================================================
module tb_dma_timing_control;
    import dma_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  DREQ, DACK, dackGrant, autoInit, tcStatus;
    logic        HLDA, READY, EOP_n_in, cntLoad;
    logic [7:0]  xferType;
    logic [1:0]  cntLoadCh, activeCh;
    logic [15:0] cntLoadVal;
    logic        HRQ, AEN, ADSTB, assertDACK, MEMR_n, MEMW_n, IOR_n, IOW_n;
    logic        EOP_n_out, decCount;
    logic [3:0]  strobes;

    int nChecks = 0;
    int nPass   = 0;

    always #5 CLK = ~CLK;

    // Bench plays the priority stage: grant is visible only while enabled.
    assign DACK    = assertDACK ? dackGrant : 4'b0000;
    assign strobes = {MEMR_n, MEMW_n, IOR_n, IOW_n};

    dma_timing_control dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK), .HLDA(HLDA),
        .READY(READY), .EOP_n_in(EOP_n_in), .xferType(xferType), .autoInit(autoInit),
        .cntLoad(cntLoad), .cntLoadCh(cntLoadCh), .cntLoadVal(cntLoadVal),
        .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB), .assertDACK(assertDACK),
        .MEMR_n(MEMR_n), .MEMW_n(MEMW_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
        .EOP_n_out(EOP_n_out), .tcStatus(tcStatus), .activeCh(activeCh),
        .decCount(decCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic loadCount(input logic [1:0] ch, input logic [15:0] val);
        cntLoad = 1'b1; cntLoadCh = ch; cntLoadVal = val;
        tick();
        cntLoad = 1'b0;
    endtask

    task automatic runTransfer(input string tag, input logic [1:0] ch,
                               input logic [3:0] s2Str, input logic [3:0] s3Str,
                               input int waits, input logic expEop,
                               input logic extEop, input logic collide);
        DREQ = 4'b0001 << ch;
        dackGrant = 4'b0001 << ch;
        tick();
        checkVal({tag, ".S0.HRQ"}, 32'(HRQ), 32'd1);
        checkVal({tag, ".S0.state"}, 32'(dut.r_state), 32'(S0));
        HLDA = 1'b1;
        tick();
        checkVal({tag, ".S1.ctl"}, {29'd0, assertDACK, AEN, ADSTB}, 32'b111);
        tick();
        checkVal({tag, ".S2.strobes"}, 32'(strobes), 32'(s2Str));
        checkVal({tag, ".S2.activeCh"}, 32'(activeCh), 32'(ch));
        checkVal({tag, ".S2.ADSTB"}, 32'(ADSTB), 32'd0);
        if (waits > 0) READY = 1'b0;
        if (extEop) EOP_n_in = 1'b0;
        tick();
        EOP_n_in = 1'b1;
        checkVal({tag, ".S3.strobes"}, 32'(strobes), 32'(s3Str));
        checkVal({tag, ".S3.decCount"}, 32'(decCount), 32'd0);
        for (int w = 0; w < waits; w++) begin
            tick();
            checkVal({tag, ".SW.strobes"}, 32'(strobes), 32'(s3Str));
            checkVal({tag, ".SW.state"}, 32'(dut.r_state), 32'(SW));
            checkVal({tag, ".SW.decCount"}, 32'(decCount), 32'd0);
        end
        READY = 1'b1;
        tick();
        checkVal({tag, ".S4.strobes"}, 32'(strobes), 32'hF);
        checkVal({tag, ".S4.decCount"}, 32'(decCount), 32'd1);
        checkVal({tag, ".S4.EOP_n_out"}, 32'(EOP_n_out), 32'(expEop));
        checkVal({tag, ".S4.HRQ"}, 32'(HRQ), 32'd1);
        if (collide) begin
            cntLoad = 1'b1; cntLoadCh = ch; cntLoadVal = 16'h0010;
        end
        DREQ = 4'b0000;
        HLDA = 1'b0;
        tick();
        cntLoad = 1'b0;
        checkVal({tag, ".SI.ctl"}, {28'd0, HRQ, AEN, assertDACK, decCount}, 32'd0);
        checkVal({tag, ".SI.EOP_n_out"}, 32'(EOP_n_out), 32'd1);
        checkVal({tag, ".SI.state"}, 32'(dut.r_state), 32'(SI));
    endtask

    initial begin
        RESET = 1'b1; DREQ = '0; dackGrant = '0; HLDA = 1'b0; READY = 1'b1;
        EOP_n_in = 1'b1; cntLoad = 1'b0; cntLoadCh = '0; cntLoadVal = '0;
        xferType = 8'b10_01_11_00;   // ch3 read, ch2 write, ch1 reserved, ch0 verify
        autoInit = 4'b0001;
        tick(); tick();
        checkVal("rst.ctl", {28'd0, HRQ, AEN, ADSTB, assertDACK}, 32'd0);
        checkVal("rst.strobes", 32'(strobes), 32'hF);
        checkVal("rst.misc", {25'd0, EOP_n_out, tcStatus, decCount, activeCh == 2'd0},
                 32'b1_0000_0_1);
        RESET = 1'b0;
        tick();

        loadCount(2'd2, 16'h0001);
        runTransfer("write", 2'd2, 4'b1101, 4'b1001, 0, 1'b1, 1'b0, 1'b0);
        checkVal("write.count", 32'(dut.u_wordCounter.r_current[2]), 32'h0000);
        checkVal("write.tc", 32'(tcStatus), 32'b0000);

        runTransfer("tc", 2'd2, 4'b1101, 4'b1001, 0, 1'b0, 1'b0, 1'b0);
        checkVal("tc.count", 32'(dut.u_wordCounter.r_current[2]), 32'hFFFF);
        checkVal("tc.tc", 32'(tcStatus), 32'b0100);

        loadCount(2'd3, 16'h0005);
        runTransfer("wait", 2'd3, 4'b0111, 4'b0110, 3, 1'b1, 1'b0, 1'b0);
        checkVal("wait.count", 32'(dut.u_wordCounter.r_current[3]), 32'h0004);

        loadCount(2'd0, 16'h0000);
        runTransfer("autoinit", 2'd0, 4'b1111, 4'b1111, 0, 1'b0, 1'b0, 1'b0);
        checkVal("autoinit.count", 32'(dut.u_wordCounter.r_current[0]), 32'h0000);
        checkVal("autoinit.tc", 32'(tcStatus), 32'b0101);

        loadCount(2'd1, 16'h0000);
        runTransfer("collide", 2'd1, 4'b1111, 4'b1111, 0, 1'b0, 1'b0, 1'b1);
        checkVal("collide.count", 32'(dut.u_wordCounter.r_current[1]), 32'h0010);
        checkVal("collide.tc", 32'(tcStatus), 32'b0101);

        runTransfer("exteop", 2'd3, 4'b0111, 4'b0110, 0, 1'b0, 1'b1, 1'b0);
        checkVal("exteop.count", 32'(dut.u_wordCounter.r_current[3]), 32'h0003);
        checkVal("exteop.tc", 32'(tcStatus), 32'b1101);

        loadCount(2'd2, 16'h0007);
        checkVal("load.tcclear", 32'(tcStatus), 32'b1001);

        // Request withdrawn while waiting for HLDA; an EOP here must be ignored.
        DREQ = 4'b0001;
        tick();
        checkVal("abort.S0.HRQ", 32'(HRQ), 32'd1);
        DREQ = 4'b0000; EOP_n_in = 1'b0;
        tick();
        EOP_n_in = 1'b1;
        checkVal("abort.HRQ", 32'(HRQ), 32'd0);
        checkVal("abort.state", 32'(dut.r_state), 32'(SI));
        checkVal("abort.strobes", 32'(strobes), 32'hF);
        tick();
        checkVal("abort.eop", 32'(EOP_n_out), 32'd1);

        // No grant in S1 sends the sequencer back to idle.
        DREQ = 4'b0010; dackGrant = 4'b0000;
        tick();
        HLDA = 1'b1;
        tick();
        checkVal("nodack.S1", 32'(assertDACK), 32'd1);
        tick();
        DREQ = 4'b0000; HLDA = 1'b0;
        checkVal("nodack.ctl", {29'd0, HRQ, AEN, assertDACK}, 32'd0);
        checkVal("nodack.state", 32'(dut.r_state), 32'(SI));
        tick();

        // Asynchronous reset in the middle of S3.
        DREQ = 4'b0100; dackGrant = 4'b0100;
        tick();
        HLDA = 1'b1;
        tick(); tick(); tick();
        checkVal("rstmid.S3.strobes", 32'(strobes), 32'b1001);
        #2 RESET = 1'b1;
        #1;
        checkVal("rstmid.strobes", 32'(strobes), 32'hF);
        checkVal("rstmid.ctl", {28'd0, HRQ, AEN, assertDACK, decCount}, 32'd0);
        checkVal("rstmid.state", 32'(dut.r_state), 32'(SI));
        checkVal("rstmid.tc", 32'(tcStatus), 32'd0);
        DREQ = '0; HLDA = 1'b0;
        tick();
        RESET = 1'b0;
        tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", nPass, nChecks);
        $fatal(1);
    end

endmodule : tb_dma_timing_control
`default_nettype wire
